result_mem_reader: RTL
======================

// Module: result_mem_reader
// PURPOSE
//  Read-side counterpart of the ALU pipeline's stage-4 result-memory write.
//  Accepts a burst command (start address, length) and reads consecutive
//  words from the 256x16 result memory's synchronous read port (1-cycle
//  latency). Streams the words out on a valid/ready interface with full
//  backpressure and marks the final beat. Used for result readback and
//  checking, alongside the pipeline.
// PARAMETERS
//  DATA_W   16   result word width
//  ADDR_W   8    memory address width (depth = 2**ADDR_W = 256)
//  LEN_W    9    command length width (0..256 words)
// PORTS
//  clk1        in   1       single clock; all logic samples on posedge clk1
//  rst         in   1       reset, synchronous, active-high
//  cmd_valid   in   1       burst command valid
//  cmd_ready   out  1       high only in IDLE
//  cmd_addr    in   ADDR_W  first word address
//  cmd_len     in   LEN_W   word count; 0 = no-op
//  mem_re      out  1       memory read enable
//  mem_raddr   out  ADDR_W  memory read address
//  mem_rdata   in   DATA_W  read data; valid the cycle after the mem_re edge
//  out_valid   out  1       output beat valid
//  out_ready   in   1       sink ready
//  out_data    out  DATA_W  output word
//  out_last    out  1       final beat of the burst
//  busy        out  1       high in any state except IDLE
//  done        out  1       1-cycle pulse when a burst completes
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; mem_re, out_valid, out_last, busy, done=0;
//   mem_raddr, out_data=0; buffer empty; in-flight read discarded.
//   Reset mid-burst aborts with no done pulse.
//  FSM IDLE -> READ on cmd handshake with cmd_len!=0. Latch addr; rem=len.
//   IDLE -> DONE on a cmd handshake with cmd_len==0.
//   READ -> DRAIN after the last read issues. DRAIN -> DONE when the last
//   beat handshakes. DONE -> IDLE after 1 cycle; done=1 only in DONE.
//  Reads: mem_re=1 in READ when rem_issue>0 and credits allow.
//   Credits: (buffer occupancy + reads in flight) < 2.
//   mem_raddr increments by 1 per issued read, wrapping mod 2**ADDR_W
//   (255 -> 0). Returned data goes into a 2-entry buffer.
//  Output: out_valid = buffer non-empty. out_data and out_last stay stable
//   while out_valid && !out_ready. out_last=1 only on the len-th beat.
//  Latency: cmd accepted at edge E0; first mem_re in the cycle after E0;
//   first out_valid after edge E0+2. With out_ready held high, 1 word/cycle.
//  Backpressure: with out_ready=0, at most 2 words are buffered and no
//   further mem_re is issued. No word is lost or duplicated.
//  Simultaneous buffer push and pop are allowed; occupancy is unchanged.
//  cmd_valid outside IDLE is ignored; cmd_ready=0 there.
//  len=256 reads every word exactly once, ending at addr-1 (mod 256).
//  Widths: rem counters are LEN_W bits; the address adder is ADDR_W bits
//   and truncates.
// STRUCTURE
//  Shared package alu_pipe_pkg: DATA_W, ADDR_W, LEN_W constants.
//   rd_state_t enum {IDLE, READ, DRAIN, DONE}.
//  One sub-module: rd_skid_buf. A 2-entry FIFO holding {data, last} with
//   push/pop, full/empty and count outputs. The FSM and credit logic sit
//   in the top module.
// TESTING
//  1 Preload mem[i]=16'hA000+i; cmd addr=8'h10 len=4, out_ready=1 ->
//    beats A010..A013 on 4 consecutive cycles, out_last on A013, done 1 cycle
//    after that beat.
//  2 cmd addr=8'hFE len=4 -> mem_raddr FE,FF,00,01; data A0FE,A0FF,A000,A001.
//  3 len=6 with out_ready toggling 1,0,0,1,... -> 6 in-order beats, no loss or
//    duplication; data held while stalled; mem_re never exceeds 2 credits.
//  4 out_ready=0 for 10 cycles after accept -> exactly 2 mem_re pulses, then
//    out_valid held with data A010 until released.
//  5 cmd len=0 -> no mem_re, no out_valid; done pulses at edge E0+1;
//    cmd_ready back to 1 next cycle.
//  6 rst asserted mid-burst on beat 2 of 8 -> all outputs at reset values next
//    cycle, no done pulse; a new cmd len=1 then returns the correct word.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared constants and types for the ALU pipeline result-memory readback path.
package alu_pipe_pkg;

  // Result word width
  localparam int DATA_W = 16;
  // Result memory address width (depth = 2**ADDR_W)
  localparam int ADDR_W = 8;
  // Burst length width; one extra bit so a full-depth burst (256) fits
  localparam int LEN_W  = 9;

  // Number of entries in the output skid buffer; also the read credit limit
  localparam int BUF_DEPTH = 2;

  // Burst reader control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage : alu_pipe_pkg

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO holding {data, last} for returned memory words.
// A push while full is accepted only when a pop happens in the same cycle,
// in which case the freed slot is the one being written.
module rd_skid_buf
  import alu_pipe_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] entry_data_reg [BUF_DEPTH];
  logic          entry_last_reg [BUF_DEPTH];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'(BUF_DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = entry_data_reg[rd_ptr_reg];
  assign head_last = entry_last_reg[rd_ptr_reg];

  // One storage slot per entry, written when the write pointer selects it
  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk1) begin
        if (rst) begin
          entry_data_reg[gi] <= '0;
          entry_last_reg[gi] <= 1'b0;
        end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          entry_data_reg[gi] <= push_data;
          entry_last_reg[gi] <= push_last;
        end
      end
    end
  endgenerate

  // Occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

endmodule : rd_skid_buf

// File: rtl/result_mem_reader.sv
// Burst reader for the 256x16 result memory. Accepts {addr, len}, issues
// sequential reads against the synchronous read port, and streams the words
// out on a valid/ready interface, tagging the final beat.
module result_mem_reader
  import alu_pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int LW = LEN_W
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  rd_state_t     state_reg;
  rd_state_t     state_next;
  logic [AW-1:0] addr_reg;
  logic [LW-1:0] rem_issue_reg;
  logic          inflight_reg;
  logic          inflight_last_reg;

  logic          buf_full;
  logic          buf_empty;
  logic [1:0]    buf_count;
  logic          buf_pop;
  logic [2:0]    occ_after_pop;
  logic          credit_ok;
  logic          cmd_fire;
  logic          issue_last;

  // Skid buffer catching words returned by the memory
  rd_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk1      (clk1),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (mem_rdata),
    .push_last (inflight_last_reg),
    .pop       (buf_pop),
    .head_data (out_data),
    .head_last (out_last),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign out_valid = !buf_empty;
  assign buf_pop   = out_valid && out_ready;
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign mem_raddr = addr_reg;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Words already held plus the one in flight, less the word leaving this
  // cycle. Counting the outgoing word lets the stream sustain 1 word/cycle
  // while still never landing a third word in the buffer.
  assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, buf_pop};
  assign credit_ok     = (occ_after_pop < 3'(BUF_DEPTH)) && !buf_full;
  assign issue_last    = (rem_issue_reg == LW'(1));

  // Next-state and read-issue decode
  always_comb begin
    state_next = state_reg;
    mem_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next = (cmd_len == LW'(0)) ? DONE : READ;
        end
      end
      READ: begin
        mem_re = (rem_issue_reg != LW'(0)) && credit_ok;
        if (mem_re && issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (buf_pop && out_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address / remaining-read counters; the address wraps naturally at 2**AW
  always_ff @(posedge clk1) begin
    if (rst) begin
      addr_reg      <= '0;
      rem_issue_reg <= '0;
    end else if (cmd_fire && (cmd_len != LW'(0))) begin
      addr_reg      <= cmd_addr;
      rem_issue_reg <= cmd_len;
    end else if (mem_re) begin
      addr_reg      <= addr_reg + AW'(1);
      rem_issue_reg <= rem_issue_reg - LW'(1);
    end
  end

  // Track the read whose data arrives next cycle; reset drops it
  always_ff @(posedge clk1) begin
    if (rst) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= mem_re;
      inflight_last_reg <= mem_re && issue_last;
    end
  end

endmodule : result_mem_reader
